decodificador_pwm: RTL and testbench

- Receive-side counterpart of the servo PWM generator: samples an incoming PWM line, measures pulse high time and period, and decodes each frame back to the 1-bit `largura` value.
- Used for loopback self-test of the servo channels and for reading PWM produced by another board.
- Sits between a board input pin and the control FSM, which consumes the one-cycle `pronto` / `erro` strobes.

---
 rtl/decodificador_pwm_if.sv | 19 +
 rtl/decodificador_pwm.sv | 156 +++++++++++++++
 tb/tb_decodificador_pwm.sv | 198 +++++++++++++++++++
 3 files changed

// File: rtl/decodificador_pwm_if.sv
// PWM receiver bus: sampled line in, decoded frame results and strobes out.
interface decodificador_pwm_if;
  logic        pwm_in;
  logic        largura;
  logic [31:0] largura_medida;
  logic [31:0] periodo_medido;
  logic        pronto;
  logic        erro;

  modport master (
    output pwm_in,
    input  largura, largura_medida, periodo_medido, pronto, erro
  );

  modport slave (
    input  pwm_in,
    output largura, largura_medida, periodo_medido, pronto, erro
  );
endinterface

// File: rtl/decodificador_pwm.sv
// PWM frame decoder: measures high time and rise-to-rise period of a
// synchronized PWM line and decodes each frame back to a 1-bit width value.
//
// state   | meaning
// ESPERA  | idle / line low, period unknown; zero-width report every T cycles
// ALTO    | line high, counting pulse width
// BAIXO   | line low after a pulse, waiting for the next rise or timeout
// TRAVADO | line stuck high; waiting for it to drop, no reports
module decodificador_pwm #(
  parameter int unsigned CONF_PERIODO = 1250,
  parameter int unsigned LARGURA_0    = 0,
  parameter int unsigned LARGURA_1    = 50,
  parameter int unsigned TOLERANCIA   = 5
) (
  input  logic                clock,
  input  logic                reset,
  decodificador_pwm_if.slave  bus
);

  localparam logic [31:0] P_CONF = 32'(CONF_PERIODO);
  localparam logic [31:0] P_L0   = 32'(LARGURA_0);
  localparam logic [31:0] P_L1   = 32'(LARGURA_1);
  localparam logic [31:0] P_TOL  = 32'(TOLERANCIA);
  localparam logic [31:0] P_TMO  = 32'(CONF_PERIODO + TOLERANCIA);

  localparam logic [1:0] ESPERA  = 2'd0;
  localparam logic [1:0] ALTO    = 2'd1;
  localparam logic [1:0] BAIXO   = 2'd2;
  localparam logic [1:0] TRAVADO = 2'd3;

  function automatic logic [31:0] dif(input logic [31:0] a, input logic [31:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  logic        pwm_m_q, pwm_s_q, pwm_d_q;
  logic [1:0]  estado_q, estado_d;
  logic [31:0] cnt_alto_q, cnt_alto_d;
  logic [31:0] cnt_per_q, cnt_per_d;
  logic        largura_q, largura_d;
  logic [31:0] larg_med_q, per_med_q;
  logic        pronto_q, erro_q, erro_d;

  logic        rise, fall, tmo;
  logic        reporta, travou;
  logic [31:0] rep_larg, rep_per;
  logic [31:0] d0, d1;
  logic        ok0, ok1, bit_k, quadro_ok;

  assign rise = pwm_s_q & ~pwm_d_q;
  assign fall = ~pwm_s_q & pwm_d_q;
  // The timeout fires on the cycle the period count would reach T.
  assign tmo  = (cnt_per_q + 32'd1) == P_TMO;

  always_comb begin
    estado_d   = estado_q;
    cnt_alto_d = cnt_alto_q;
    cnt_per_d  = cnt_per_q + 32'd1;
    reporta    = 1'b0;
    travou     = 1'b0;
    rep_larg   = cnt_alto_q;
    rep_per    = cnt_per_q;
    case (estado_q)
      ESPERA: begin
        if (rise) begin
          estado_d   = ALTO;
          cnt_alto_d = 32'd1;
          cnt_per_d  = 32'd1;
        end else if (tmo) begin
          reporta   = 1'b1;
          rep_larg  = 32'd0;
          rep_per   = 32'd0;
          cnt_per_d = 32'd0;
        end
      end
      ALTO: begin
        if (fall) begin
          estado_d = BAIXO;
        end else if (cnt_alto_q == P_CONF) begin
          travou   = 1'b1;
          estado_d = TRAVADO;
        end else begin
          cnt_alto_d = cnt_alto_q + 32'd1;
        end
      end
      BAIXO: begin
        // A rise coinciding with the timeout is a valid frame edge.
        if (rise) begin
          reporta    = 1'b1;
          estado_d   = ALTO;
          cnt_alto_d = 32'd1;
          cnt_per_d  = 32'd1;
        end else if (tmo) begin
          reporta   = 1'b1;
          rep_per   = 32'd0;
          estado_d  = ESPERA;
          cnt_per_d = 32'd0;
        end
      end
      default: begin
        if (!pwm_s_q) begin
          estado_d  = ESPERA;
          cnt_per_d = 32'd0;
        end
      end
    endcase
  end

  // Nearer nominal width wins; ties resolve to bit 0.
  always_comb begin
    d0        = dif(rep_larg, P_L0);
    d1        = dif(rep_larg, P_L1);
    ok0       = d0 <= P_TOL;
    ok1       = d1 <= P_TOL;
    bit_k     = ok1 & (~ok0 | (d1 < d0));
    quadro_ok = (ok0 | ok1) & ((rep_per == 32'd0) | (dif(rep_per, P_CONF) <= P_TOL));
    largura_d = (reporta && quadro_ok) ? bit_k : largura_q;
    erro_d    = (reporta & ~quadro_ok) | travou;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      pwm_m_q    <= 1'b0;
      pwm_s_q    <= 1'b0;
      pwm_d_q    <= 1'b0;
      estado_q   <= ESPERA;
      cnt_alto_q <= 32'd0;
      cnt_per_q  <= 32'd0;
      largura_q  <= 1'b0;
      larg_med_q <= 32'd0;
      per_med_q  <= 32'd0;
      pronto_q   <= 1'b0;
      erro_q     <= 1'b0;
    end else begin
      pwm_m_q    <= bus.pwm_in;
      pwm_s_q    <= pwm_m_q;
      pwm_d_q    <= pwm_s_q;
      estado_q   <= estado_d;
      cnt_alto_q <= cnt_alto_d;
      cnt_per_q  <= cnt_per_d;
      largura_q  <= largura_d;
      pronto_q   <= reporta;
      erro_q     <= erro_d;
      if (reporta) begin
        larg_med_q <= rep_larg;
        per_med_q  <= rep_per;
      end
    end
  end

  assign bus.largura        = largura_q;
  assign bus.largura_medida = larg_med_q;
  assign bus.periodo_medido = per_med_q;
  assign bus.pronto         = pronto_q;
  assign bus.erro           = erro_q;

endmodule

// File: tb/tb_decodificador_pwm.sv
// Directed bench for decodificador_pwm: frame table plus reset, idle-line,
// stuck-high and pulse-then-silence sequences.
module tb_decodificador_pwm;

  localparam int T = 1255;

  logic clock = 1'b0;
  logic reset = 1'b0;
  int   cyc = 0;

  decodificador_pwm_if bus ();

  decodificador_pwm dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] med;
    logic [31:0] per;
    logic        larg;
    logic        err;
    int          cyc;
  } rep_t;

  typedef struct {
    int          w;
    int          p;
    logic [31:0] e_med;
    logic [31:0] e_per;
    logic        e_larg;
    logic        e_erro;
  } vec_t;

  rep_t rep_q[$];
  int   rd_idx = 0;
  int   erro_solo = 0;
  int   n_vec = 0;
  int   n_err = 0;

  always @(negedge clock) begin
    if (bus.pronto)
      rep_q.push_back('{bus.largura_medida, bus.periodo_medido, bus.largura, bus.erro, cyc});
    if (bus.erro && !bus.pronto)
      erro_solo <= erro_solo + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic chk_rng(input string nm, input int act, input int lo, input int hi);
    n_vec++;
    if (act < lo || act > hi) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
    end
  endtask

  task automatic take_rep(input string nm, input int budget, input logic [31:0] em,
                          input logic [31:0] ep, input logic el, input logic ee,
                          output int stamp);
    rep_t r;
    int   n = 0;
    while (rep_q.size() <= rd_idx && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (rep_q.size() <= rd_idx) begin
      n_vec++;
      n_err++;
      $display("FAIL %s: no report within %0d cycles", nm, budget);
      stamp = -1;
    end else begin
      r = rep_q[rd_idx];
      rd_idx++;
      chk({nm, " largura_medida"}, r.med, em);
      chk({nm, " periodo_medido"}, r.per, ep);
      chk({nm, " largura"}, {31'd0, r.larg}, {31'd0, el});
      chk({nm, " erro"}, {31'd0, r.err}, {31'd0, ee});
      stamp = r.cyc;
    end
  endtask

  task automatic frame(input int w, input int p);
    bus.pwm_in = 1'b1;
    repeat (w) @(negedge clock);
    bus.pwm_in = 1'b0;
    repeat (p - w) @(negedge clock);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " largura"}, {31'd0, bus.largura}, 32'd0);
    chk({nm, " largura_medida"}, bus.largura_medida, 32'd0);
    chk({nm, " periodo_medido"}, bus.periodo_medido, 32'd0);
    chk({nm, " pronto"}, {31'd0, bus.pronto}, 32'd0);
    chk({nm, " erro"}, {31'd0, bus.erro}, 32'd0);
  endtask

  initial begin
    #(10 * 200000);
    $display("FAIL watchdog: bench did not complete");
    $fatal(1);
  end

  initial begin
    vec_t vec[13];
    int   s0, s1, s2, c0, base_solo, base_n;

    vec[0]  = '{50, 1250, 32'd50, 32'd1250, 1'b1, 1'b0};
    vec[1]  = '{50, 1250, 32'd50, 32'd1250, 1'b1, 1'b0};
    vec[2]  = '{30, 1250, 32'd30, 32'd1250, 1'b1, 1'b1};
    vec[3]  = '{3,  1250, 32'd3,  32'd1250, 1'b0, 1'b0};
    vec[4]  = '{50, 1244, 32'd50, 32'd1244, 1'b0, 1'b1};
    vec[5]  = '{54, 1246, 32'd54, 32'd1246, 1'b1, 1'b0};
    vec[6]  = '{45, 1254, 32'd45, 32'd1254, 1'b1, 1'b0};
    vec[7]  = '{6,  1250, 32'd6,  32'd1250, 1'b1, 1'b1};
    vec[8]  = '{25, 1250, 32'd25, 32'd1250, 1'b1, 1'b1};
    vec[9]  = '{5,  1245, 32'd5,  32'd1245, 1'b0, 1'b0};
    vec[10] = '{56, 1250, 32'd56, 32'd1250, 1'b0, 1'b1};
    vec[11] = '{50, 1240, 32'd50, 32'd1240, 1'b0, 1'b1};
    vec[12] = '{50, 1250, 32'd50, 32'd1250, 1'b1, 1'b0};

    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clock);
    chk_zero("reset");

    // Idle line: zero-width reports every T cycles.
    reset = 1'b1;
    c0 = cyc;
    take_rep("idle0", T + 10, 32'd0, 32'd0, 1'b0, 1'b0, s0);
    take_rep("idle1", T + 10, 32'd0, 32'd0, 1'b0, 1'b0, s1);
    take_rep("idle2", T + 10, 32'd0, 32'd0, 1'b0, 1'b0, s2);
    chk_rng("idle first report", s0 - c0, T, T + 2);
    chk("idle interval 1", 32'(s1 - s0), 32'(T));
    chk("idle interval 2", 32'(s2 - s1), 32'(T));

    // Frame table: each frame is reported at the next rise.
    for (int v = 0; v < 13; v++) begin
      frame(vec[v].w, vec[v].p);
      if (v > 0)
        take_rep($sformatf("vec%0d", v - 1), 5, vec[v-1].e_med, vec[v-1].e_per,
                 vec[v-1].e_larg, vec[v-1].e_erro, s0);
    end

    // Single pulse then silence: last table frame, then a timeout report.
    c0 = cyc;
    bus.pwm_in = 1'b1;
    repeat (50) @(negedge clock);
    bus.pwm_in = 1'b0;
    take_rep("vec12", 5, vec[12].e_med, vec[12].e_per, vec[12].e_larg, vec[12].e_erro, s0);
    take_rep("silence", T + 10, 32'd50, 32'd0, 1'b1, 1'b0, s1);
    chk_rng("silence latency", s1 - c0, T, T + 3);

    // Stuck high line.
    base_solo = erro_solo;
    base_n = rep_q.size();
    bus.pwm_in = 1'b1;
    repeat (3000) @(negedge clock);
    chk("stuck erro count", 32'(erro_solo - base_solo), 32'd1);
    chk("stuck pronto count", 32'(rep_q.size() - base_n), 32'd0);
    c0 = cyc;
    bus.pwm_in = 1'b0;
    take_rep("stuck release", T + 10, 32'd0, 32'd0, 1'b0, 1'b0, s0);
    chk_rng("stuck release latency", s0 - c0, T, T + 3);

    // Reset in the middle of a pulse.
    frame(50, 1250);
    bus.pwm_in = 1'b1;
    repeat (25) @(negedge clock);
    take_rep("pre-reset", 5, 32'd50, 32'd1250, 1'b1, 1'b0, s0);
    reset = 1'b0;
    #1;
    chk_zero("mid reset");
    bus.pwm_in = 1'b0;
    repeat (3) @(negedge clock);
    reset = 1'b1;
    base_n = rep_q.size();
    frame(50, 1250);
    chk("post-reset first rise silent", 32'(rep_q.size() - base_n), 32'd0);
    bus.pwm_in = 1'b1;
    repeat (5) @(negedge clock);
    chk("post-reset report count", 32'(rep_q.size() - base_n), 32'd1);
    take_rep("post-reset", 5, 32'd50, 32'd1250, 1'b1, 1'b0, s0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
